// File: rtl/counter_event_monitor_if.sv
// Bundles the counter sample stream, the interrupt handshake and the monitor status
// outputs. The slave modport is the monitor; the master modport is the side that drives it.
interface counter_event_monitor_if #(
  parameter int WIDTH = 5,
  parameter int EVT_W = 8
);
  logic [WIDTH-1:0] cnt_in;
  logic             cnt_valid;
  logic             irq_ack;
  logic             clr_sticky;
  logic             irq;
  logic             wrap_pulse;
  logic             seq_err;
  logic             irq_overrun;
  logic [EVT_W-1:0] evt_count;

  modport master (
    output cnt_in, cnt_valid, irq_ack, clr_sticky,
    input  irq, wrap_pulse, seq_err, irq_overrun, evt_count
  );

  modport slave (
    input  cnt_in, cnt_valid, irq_ack, clr_sticky,
    output irq, wrap_pulse, seq_err, irq_overrun, evt_count
  );
endinterface

// File: rtl/counter_event_monitor.sv
// Watches a free-running counter for +1 continuity, flags legal wraps, counts
// matches against MATCH_VAL and raises a level interrupt with a 4-phase req/ack.
module counter_event_monitor #(
  parameter int WIDTH     = 5,
  parameter int MATCH_VAL = 20,
  parameter int EVT_W     = 8
) (
  input logic                   clk,
  input logic                   rst,
  counter_event_monitor_if.slave bus
);

  localparam logic [WIDTH-1:0] LP_MATCH = WIDTH'(MATCH_VAL);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PENDING,
    ST_RELEASE
  } state_t;

  state_t           r_state;
  logic             r_have_prev;
  logic [WIDTH-1:0] r_prev_cnt;
  logic             r_irq;
  logic             r_wrap_pulse;
  logic             r_seq_err;
  logic             r_irq_overrun;
  logic [EVT_W-1:0] r_evt_count;

  logic [WIDTH-1:0] w_expected;
  logic             w_checked;
  logic             w_match;
  logic             w_seq_bad;
  logic             w_wrap;
  logic             w_overrun;
  logic [EVT_W-1:0] w_evt_inc;

  always_comb begin
    w_expected = r_prev_cnt + WIDTH'(1);
    w_checked  = bus.cnt_valid && r_have_prev;
    w_match    = bus.cnt_valid && (bus.cnt_in == LP_MATCH);
    w_seq_bad  = w_checked && (bus.cnt_in != w_expected);
    w_wrap     = w_checked && (r_prev_cnt == '1) && (bus.cnt_in == '0);
    w_overrun  = w_match && (r_state != ST_IDLE);
    w_evt_inc  = (r_evt_count == '1) ? r_evt_count : r_evt_count + EVT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_have_prev   <= 1'b0;
      r_prev_cnt    <= '0;
      r_irq         <= 1'b0;
      r_wrap_pulse  <= 1'b0;
      r_seq_err     <= 1'b0;
      r_irq_overrun <= 1'b0;
      r_evt_count   <= '0;
    end else begin
      if (bus.cnt_valid) begin
        r_prev_cnt  <= bus.cnt_in;
        r_have_prev <= 1'b1;
      end

      r_wrap_pulse <= w_wrap;

      // Set beats clear so a fault coinciding with the clear is never lost.
      if (w_seq_bad)           r_seq_err <= 1'b1;
      else if (bus.clr_sticky) r_seq_err <= 1'b0;

      if (w_overrun)           r_irq_overrun <= 1'b1;
      else if (bus.clr_sticky) r_irq_overrun <= 1'b0;

      if (bus.clr_sticky)      r_evt_count <= w_match ? EVT_W'(1) : '0;
      else if (w_match)        r_evt_count <= w_evt_inc;

      // irq is registered alongside the state so it tracks PENDING exactly.
      case (r_state)
        ST_IDLE: begin
          if (w_match) begin
            r_state <= ST_PENDING;
            r_irq   <= 1'b1;
          end
        end
        ST_PENDING: begin
          if (bus.irq_ack) begin
            r_state <= ST_RELEASE;
            r_irq   <= 1'b0;
          end
        end
        ST_RELEASE: begin
          if (!bus.irq_ack) r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_irq   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.irq         = r_irq;
  assign bus.wrap_pulse  = r_wrap_pulse;
  assign bus.seq_err     = r_seq_err;
  assign bus.irq_overrun = r_irq_overrun;
  assign bus.evt_count   = r_evt_count;

endmodule

// File: tb/tb_counter_event_monitor.sv
// Directed bench for counter_event_monitor: a default instance and an EVT_W=2 instance
// share one stimulus stream and are checked every cycle against a behavioural model.
module tb_counter_event_monitor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  counter_event_monitor_if #(.WIDTH(5), .EVT_W(8)) bus8 ();
  counter_event_monitor_if #(.WIDTH(5), .EVT_W(2)) bus2 ();

  assign bus2.cnt_in     = bus8.cnt_in;
  assign bus2.cnt_valid  = bus8.cnt_valid;
  assign bus2.irq_ack    = bus8.irq_ack;
  assign bus2.clr_sticky = bus8.clr_sticky;

  counter_event_monitor #(.WIDTH(5), .MATCH_VAL(20), .EVT_W(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8.slave)
  );

  counter_event_monitor #(.WIDTH(5), .MATCH_VAL(20), .EVT_W(2)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2.slave)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Behavioural model: outstanding interrupt + whether the ack has been seen.
  bit m_ok = 0;
  int m_prev = 0;
  bit m_have = 0;
  bit m_busy = 0;
  bit m_acked = 0;
  bit m_irq = 0, m_wrap = 0, m_seq = 0, m_ovr = 0;
  int m_evt = 0;

  always @(posedge clk) begin
    bit match, wrap, badseq, ovr;
    int cin;
    if (rst) begin
      m_ok = 1; m_prev = 0; m_have = 0; m_busy = 0; m_acked = 0;
      m_irq = 0; m_wrap = 0; m_seq = 0; m_ovr = 0; m_evt = 0;
    end else begin
      cin    = int'(bus8.cnt_in);
      match  = bus8.cnt_valid && cin == 20;
      wrap   = bus8.cnt_valid && m_have && m_prev == 31 && cin == 0;
      badseq = bus8.cnt_valid && m_have && cin != (m_prev + 1) % 32;
      ovr    = match && m_busy;
      if (bus8.cnt_valid) begin
        m_prev = cin;
        m_have = 1;
      end
      if (!m_busy) begin
        if (match) begin
          m_busy  = 1;
          m_acked = 0;
        end
      end else if (!m_acked) begin
        if (bus8.irq_ack) m_acked = 1;
      end else if (!bus8.irq_ack) begin
        m_busy = 0;
      end
      m_irq  = m_busy && !m_acked;
      m_wrap = wrap;
      m_seq  = badseq ? 1'b1 : (bus8.clr_sticky ? 1'b0 : m_seq);
      m_ovr  = ovr ? 1'b1 : (bus8.clr_sticky ? 1'b0 : m_ovr);
      m_evt  = bus8.clr_sticky ? int'(match) : m_evt + int'(match);
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("irq", int'(bus8.irq), int'(m_irq));
      chk("wrap_pulse", int'(bus8.wrap_pulse), int'(m_wrap));
      chk("seq_err", int'(bus8.seq_err), int'(m_seq));
      chk("irq_overrun", int'(bus8.irq_overrun), int'(m_ovr));
      chk("evt_count", int'(bus8.evt_count), (m_evt > 255) ? 255 : m_evt);
      chk("evt_count_w2", int'(bus2.evt_count), (m_evt > 3) ? 3 : m_evt);
      chk("irq_w2", int'(bus2.irq), int'(m_irq));
    end
  end

  int last = 0;

  task automatic step(input bit v, input int c, input bit a, input bit cl);
    @(negedge clk);
    bus8.cnt_valid  = v;
    bus8.cnt_in     = 5'(c);
    bus8.irq_ack    = a;
    bus8.clr_sticky = cl;
    @(posedge clk);
    #1;
  endtask

  task automatic feed_to(input int target);
    do begin
      last = (last + 1) % 32;
      step(1, last, 0, 0);
    end while (last != target);
  endtask

  int sat_tbl [5] = '{1, 2, 3, 3, 3};

  initial begin
    bus8.cnt_valid  = 0;
    bus8.cnt_in     = '0;
    bus8.irq_ack    = 0;
    bus8.clr_sticky = 0;
    rst = 1;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    rst = 0;
    chk("reset_irq", int'(bus8.irq), 0);
    chk("reset_evt", int'(bus8.evt_count), 0);
    chk("reset_seq", int'(bus8.seq_err), 0);

    // Free run 0..31,0,1
    for (int i = 0; i < 32; i++) begin
      step(1, i, 0, 0);
      if (i == 20) begin
        chk("free_irq_at_20", int'(bus8.irq), 1);
        chk("free_evt_at_20", int'(bus8.evt_count), 1);
      end
    end
    step(1, 0, 0, 0);
    chk("free_wrap", int'(bus8.wrap_pulse), 1);
    step(1, 1, 0, 0);
    chk("free_wrap_drop", int'(bus8.wrap_pulse), 0);
    chk("free_seq", int'(bus8.seq_err), 0);
    last = 1;

    // Handshake
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    chk("hs_irq_drop", int'(bus8.irq), 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    feed_to(20);
    chk("hs_irq_again", int'(bus8.irq), 1);
    chk("hs_evt2", int'(bus8.evt_count), 2);
    chk("hs_ovr", int'(bus8.irq_overrun), 0);

    // Overrun: two more matches without ack
    step(0, 0, 0, 1);
    feed_to(31);
    feed_to(31);
    feed_to(31);
    chk("ovr_irq", int'(bus8.irq), 1);
    chk("ovr_set", int'(bus8.irq_overrun), 1);
    chk("ovr_evt", int'(bus8.evt_count), 2);
    step(0, 0, 0, 1);
    chk("ovr_clr", int'(bus8.irq_overrun), 0);
    chk("ovr_clr_evt", int'(bus8.evt_count), 0);
    chk("ovr_clr_irq", int'(bus8.irq), 1);

    // Sequence faults
    feed_to(6);
    chk("seq_before_stall", int'(bus8.seq_err), 0);
    step(1, 6, 0, 0);
    chk("seq_stall", int'(bus8.seq_err), 1);
    step(0, 0, 0, 1);
    chk("seq_clr", int'(bus8.seq_err), 0);
    feed_to(10);
    step(1, 0, 0, 0);
    last = 0;
    chk("seq_jump0", int'(bus8.seq_err), 1);
    chk("seq_jump0_nowrap", int'(bus8.wrap_pulse), 0);
    step(0, 0, 0, 1);
    feed_to(4);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(1, 5, 0, 0);
    last = 5;
    chk("seq_gap_ok", int'(bus8.seq_err), 0);

    // Saturation on the EVT_W=2 instance
    step(0, 0, 0, 1);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      feed_to(20);
      chk("sat_w2", int'(bus2.evt_count), sat_tbl[k]);
      chk("sat_w8", int'(bus8.evt_count), k + 1);
      step(0, 0, 1, 0);
      step(0, 0, 0, 0);
    end
    chk("sat_no_ovr", int'(bus8.irq_overrun), 0);

    // Reset mid-handshake
    feed_to(20);
    chk("rst_pre_irq", int'(bus8.irq), 1);
    rst = 1;
    step(0, 0, 0, 0);
    rst = 0;
    chk("rst_irq", int'(bus8.irq), 0);
    chk("rst_evt", int'(bus8.evt_count), 0);
    chk("rst_ovr", int'(bus8.irq_overrun), 0);
    step(1, 17, 0, 0);
    chk("rst_first_sample", int'(bus8.seq_err), 0);
    step(1, 18, 0, 0);
    step(1, 20, 0, 0);
    chk("rst_skip_err", int'(bus8.seq_err), 1);
    chk("rst_skip_irq", int'(bus8.irq), 1);

    step(0, 0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
